// File: rtl/ff_mode_bank_pkg.sv
// ============================================================================
// ff_mode_bank_pkg : mode encodings shared by the flip-flop bank
// Rev 1.0
// ============================================================================
`default_nettype none

package ff_mode_bank_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_D  = 2'b00;
  localparam mode_t MODE_T  = 2'b01;
  localparam mode_t MODE_JK = 2'b10;
  localparam mode_t MODE_SR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ff_mode_bank_tff_cell.sv
// ============================================================================
// tff_cell : WIDTH-bit toggle register with synchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module tff_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (sclr) begin
      r_q <= '0;
    end else begin
      r_q <= r_q ^ t;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/ff_mode_bank.sv
// ============================================================================
// ff_mode_bank : D/T/JK/SR flip-flop bank; FF_MODE_BANK_ACTIVITY_EN adds a
//                saturating toggle counter
// Rev 1.0
// ============================================================================
`default_nettype none

module ff_mode_bank
  import ff_mode_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  input  logic             act_clr,
  output logic [WIDTH-1:0] q,
  output logic             changed,
  output logic             sr_err,
  output logic [CNT_W-1:0] act_cnt
);

  mode_t            w_mode;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_upd;
  logic             r_changed;
  logic             r_sr_err;

  assign w_mode = mode;
  assign w_upd  = en && !sclr;

  always_comb begin
    w_next = q;
    case (w_mode)
      MODE_D:  w_next = a;
      MODE_T:  w_next = q ^ a;
      MODE_JK: w_next = (a & ~q) | (~b & q);
      // a=b=1 is the illegal SR pair: hold those bits
      MODE_SR: w_next = ((a | (q & ~b)) & ~(a & b)) | (q & a & b);
      default: w_next = q;
    endcase
  end

  // Only real updates toggle; sclr is applied inside the cell
  assign w_t = w_upd ? (w_next ^ q) : '0;

  tff_cell #(
    .WIDTH(WIDTH)
  ) u_cell (
    .clk  (clk),
    .rst  (rst),
    .sclr (sclr),
    .t    (w_t),
    .q    (q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else if (sclr) begin
      r_changed <= |q;
    end else if (en) begin
      r_changed <= |w_t;
    end else begin
      r_changed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr_err <= 1'b0;
    end else if (w_upd && (w_mode == MODE_SR) && |(a & b)) begin
      r_sr_err <= 1'b1;
    end else if (err_clr) begin
      r_sr_err <= 1'b0;
    end
  end

  assign changed = r_changed;
  assign sr_err  = r_sr_err;

`ifdef FF_MODE_BANK_ACTIVITY_EN
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [POP_W-1:0] w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] r_act_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + POP_W'(w_t[i]);
    end
  end

  assign w_sum = SUM_W'(r_act_cnt) + SUM_W'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_cnt <= '0;
    end else if (act_clr) begin
      r_act_cnt <= '0;
    end else if (w_upd) begin
      // Any carry past CNT_W bits pins the counter at all-ones
      if (|w_sum[SUM_W-1:CNT_W]) begin
        r_act_cnt <= '1;
      end else begin
        r_act_cnt <= w_sum[CNT_W-1:0];
      end
    end
  end

  assign act_cnt = r_act_cnt;
`else
  logic w_unused_act_clr;

  assign w_unused_act_clr = act_clr;
  assign act_cnt          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ff_mode_bank.sv
// ============================================================================
// tb_ff_mode_bank : scoreboard bench for ff_mode_bank (WIDTH=8, CNT_W=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ff_mode_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             changed;
    logic             sr_err;
    logic [CNT_W-1:0] act;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             sclr = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             err_clr = 1'b0;
  logic             act_clr = 1'b0;
  logic [WIDTH-1:0] q;
  logic             changed;
  logic             sr_err;
  logic [CNT_W-1:0] act_cnt;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  logic [WIDTH-1:0] m_q = '0;
  logic             m_err = 1'b0;
  int               m_act = 0;

  ff_mode_bank #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sclr    (sclr),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .err_clr (err_clr),
    .act_clr (act_clr),
    .q       (q),
    .changed (changed),
    .sr_err  (sr_err),
    .act_cnt (act_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truth-table form of each flip-flop type, one bit at a time
  function automatic logic ref_bit(input logic [1:0] md, input logic qb, input logic ab, input logic bb);
    case (md)
      2'b00:   return ab;
      2'b01:   return ab ? ~qb : qb;
      2'b10:   return ab ? (bb ? ~qb : 1'b1) : (bb ? 1'b0 : qb);
      default: return (ab == bb) ? qb : ab;
    endcase
  endfunction

  task automatic step(input logic i_en, input logic i_sclr, input logic [1:0] i_mode,
                      input logic [WIDTH-1:0] i_a, input logic [WIDTH-1:0] i_b,
                      input logic i_err_clr, input logic i_act_clr, input string tag);
    exp_t             e;
    exp_t             got;
    logic [WIDTH-1:0] nq;
    logic             ch;
    logic             set_err;
    @(negedge clk);
    en = i_en; sclr = i_sclr; mode = i_mode; a = i_a; b = i_b;
    err_clr = i_err_clr; act_clr = i_act_clr;
    nq = m_q; ch = 1'b0; set_err = 1'b0;
    if (i_sclr) begin
      nq = '0;
      ch = (m_q != 0);
    end else if (i_en) begin
      for (int i = 0; i < WIDTH; i++) nq[i] = ref_bit(i_mode, m_q[i], i_a[i], i_b[i]);
      ch = (nq != m_q);
      set_err = (i_mode == 2'b11) && ((i_a & i_b) != 0);
`ifdef FF_MODE_BANK_ACTIVITY_EN
      m_act = m_act + $countones(nq ^ m_q);
      if (m_act > 15) m_act = 15;
`endif
    end
    if (i_act_clr) m_act = 0;
    if (set_err) m_err = 1'b1;
    else if (i_err_clr) m_err = 1'b0;
    m_q = nq;
    e.q = m_q; e.changed = ch; e.sr_err = m_err; e.act = CNT_W'(m_act);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      check_val({tag, " q"}, q, got.q);
      check_val({tag, " changed"}, changed, got.changed);
      check_val({tag, " sr_err"}, sr_err, got.sr_err);
      check_val({tag, " act_cnt"}, act_cnt, got.act);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("reset q", q, 0);
    check_val("reset changed", changed, 0);
    check_val("reset sr_err", sr_err, 0);
    check_val("reset act_cnt", act_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // D mode, then an identical repeat
    step(1, 0, 2'b00, 8'h3C, 8'h00, 0, 0, "d_first");
    step(1, 0, 2'b00, 8'h3C, 8'h00, 0, 0, "d_repeat");
    step(0, 0, 2'b00, 8'h00, 8'h00, 0, 1, "act_clr_idle");
    // Toggle all bits four times, counter saturates
    for (int i = 0; i < 4; i++) step(1, 0, 2'b01, 8'hFF, 8'h00, 0, 0, "t_ff");
    // Hold with random operands
    for (int i = 0; i < 3; i++)
      step(0, 0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0, 0, "hold");
    // sclr without en
    step(1, 0, 2'b00, 8'h5A, 8'h00, 0, 0, "load_5a");
    step(0, 1, 2'b01, 8'hFF, 8'h00, 0, 0, "sclr");
    step(0, 1, 2'b00, 8'hFF, 8'h00, 0, 0, "sclr_zero");
    // act_clr beats same-cycle increment
    step(1, 0, 2'b01, 8'h01, 8'h00, 0, 1, "act_clr_t");
    // JK and SR
    step(1, 0, 2'b00, 8'hF0, 8'h00, 0, 0, "load_f0");
    step(1, 0, 2'b10, 8'h0F, 8'hFF, 0, 0, "jk");
    step(1, 0, 2'b10, 8'h33, 8'h55, 0, 0, "jk_mix");
    step(1, 1, 2'b00, 8'h00, 8'h00, 0, 0, "sclr_en");
    step(1, 0, 2'b11, 8'h81, 8'h01, 0, 0, "sr");
    step(1, 0, 2'b11, 8'h01, 8'h01, 1, 0, "sr_set_wins");
    step(0, 0, 2'b11, 8'h01, 8'h01, 1, 0, "err_clr");
    step(1, 0, 2'b11, 8'h3C, 8'h0F, 0, 0, "sr_mix");
    step(0, 0, 2'b00, 8'h00, 8'h00, 1, 0, "err_clr2");
    // Build q=A5, act=7 (where counted), sr_err=1
    step(0, 1, 2'b00, 8'h00, 8'h00, 0, 1, "prep_clr");
    step(1, 0, 2'b00, 8'h01, 8'h00, 0, 0, "prep_01");
    step(0, 1, 2'b00, 8'h00, 8'h00, 0, 0, "prep_sclr");
    step(1, 0, 2'b00, 8'h02, 8'h00, 0, 0, "prep_02");
    step(1, 0, 2'b00, 8'hA5, 8'h00, 0, 0, "prep_a5");
    step(1, 0, 2'b11, 8'hFF, 8'hFF, 0, 0, "prep_err");
    // Asynchronous reset mid-cycle
    @(negedge clk);
    en = 1'b0; sclr = 1'b0; err_clr = 1'b0; act_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst q", q, 0);
    check_val("async_rst changed", changed, 0);
    check_val("async_rst sr_err", sr_err, 0);
    check_val("async_rst act_cnt", act_cnt, 0);
    m_q = '0; m_err = 1'b0; m_act = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 2'b01, 8'h0F, 8'h00, 0, 0, "post_rst_t");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ff_mode_bank.md
FF_MODE_BANK -- requirements
Module: ff_mode_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of flip-flop bits in the bank (1..64).
REQ-002 Parameter CNT_W, default 16, width of the activity counter (4..32).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  update enable; bank holds when low.
REQ-006 sclr  input  1  synchronous clear of q.
REQ-007 mode  input  2  bank mode: 00 D, 01 T, 10 JK, 11 SR.
REQ-008 a  input  WIDTH  D / T / J / S operand per bit.
REQ-009 b  input  WIDTH  K / R operand per bit; ignored in D and T modes.
REQ-010 err_clr  input  1  synchronous clear of sr_err.
REQ-011 act_clr  input  1  synchronous clear of act_cnt.
REQ-012 q  output  WIDTH  registered bank state.
REQ-013 changed  output  1  registered; high for one cycle after an update that altered q.
REQ-014 sr_err  output  1  sticky flag: illegal SR combination seen.
REQ-015 act_cnt  output  CNT_W  saturating count of bit toggles.

Function
REQ-016 Every bit SHALL be stored in a T-type cell; the next state SHALL be produced only by computing t = next ^ q and toggling.
REQ-017 Next state per bit: D: a; T: q^a; JK: (a&~q)|(~b&q); SR: a|(q&~b), except a=b=1, which SHALL hold q.
REQ-018 Priority SHALL be sclr > en > hold; sclr drives q to 0 regardless of en and mode.
REQ-019 With en=0 and sclr=0, q, changed (forced 0), and act_cnt SHALL hold; sr_err SHALL only change via err_clr.
REQ-020 Latency SHALL be one cycle: inputs sampled at edge N appear on q after edge N.
REQ-021 changed SHALL be 1 after edge N iff edge N performed an en or sclr update with next != q; otherwise 0.
REQ-022 sr_err SHALL set on an edge with en=1, sclr=0, mode=11 and any bit of a&b set; it remains set until err_clr.
REQ-023 Simultaneous sr_err set condition and err_clr SHALL leave sr_err=1 (set wins).
REQ-024 On each en update (sclr=0), act_cnt SHALL add popcount(t); sclr updates SHALL NOT count.
REQ-025 act_cnt SHALL saturate at all-ones and never wrap.
REQ-026 act_clr SHALL zero act_cnt and take priority over a same-cycle increment (result 0).
REQ-027 mode changes SHALL take effect on the same edge they are sampled; no internal mode state.

Reset
REQ-028 rst SHALL asynchronously force q=0, changed=0, sr_err=0, act_cnt=0.
REQ-029 rst asserted mid-operation SHALL discard all state; first update after deassertion uses q=0.

Configuration
REQ-030 Macro FF_MODE_BANK_ACTIVITY_EN defined: activity counter, act_clr and act_cnt behave per REQ-024..026.
REQ-031 Macro undefined: no counter logic; act_cnt SHALL be tied to 0 and act_clr ignored; all other behaviour unchanged.

Structure
REQ-032 Package ff_mode_bank_pkg SHALL hold mode constants MODE_D, MODE_T, MODE_JK, MODE_SR and the 2-bit mode typedef.
REQ-033 Sub-module tff_cell (parametrised width, async active-high reset, toggle-on-t, sync clear) SHALL hold q; next-state, flags and counter stay in ff_mode_bank.

Verification (WIDTH=8, CNT_W=4)
REQ-034 rst pulse mid-run with q=0xA5, act_cnt=7, sr_err=1 -> all outputs 0 immediately, before next edge.
REQ-035 D mode a=0x3C from q=0 -> q=0x3C, changed=1, act_cnt=4; repeat a=0x3C -> changed=0, act_cnt=4.
REQ-036 T mode a=0xFF four updates from q=0 -> q=0xFF,0x00,0xFF,0x00; act_cnt saturates at 15 (8+8 capped).
REQ-037 JK mode q=0xF0, a=0x0F, b=0xFF -> q=0x0F; SR mode q=0x00, a=0x81, b=0x01 -> q=0x80, sr_err=1; err_clr with SR a=b=0x01 -> sr_err stays 1.
REQ-038 en=0 with sclr=1, q=0x5A -> q=0x00, changed=1, act_cnt unchanged; act_clr with en=1 T a=0x01 -> act_cnt=0.
REQ-039 Build without FF_MODE_BANK_ACTIVITY_EN, T mode a=0xFF -> q toggles, act_cnt stays 0.
